// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator: each channel pulses at num/den of refclk,
// with a two-stage config write port and a lock flag. Define CLKEN_GEN_SYNC_EN to realign all phases on every write.
module clken_gen #(
   parameter int  CHANNELS    = 3,
   parameter int  ACC_W       = 24,
   parameter int  LOCK_CYCLES = 16,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                refclk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [ACC_W-1:0]    cfg_num,
   input  logic [ACC_W-1:0]    cfg_den,
   output logic                cfg_ready,
   output logic [CHANNELS-1:0] outce,
   output logic                locked
);

   localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

   typedef enum logic {
      ST_SETTLING,
      ST_LOCKED
   } lock_state_t;

   // ------------------------------------------------------------------
   // Configuration write port: ACCEPT into staging, APPLY on the next edge
   // ------------------------------------------------------------------
   logic [CH_W-1:0]  stg_ch;
   logic [ACC_W-1:0] stg_num;
   logic [ACC_W-1:0] stg_den;
   logic             accept;
   logic             apply;
   logic             apply_valid;

   assign accept      = cfg_we & cfg_ready;
   assign apply       = ~cfg_ready;
   assign apply_valid = apply & (int'(stg_ch) < CHANNELS);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_ready <= 1'b1;
         stg_ch    <= '0;
         stg_num   <= '0;
         stg_den   <= '0;
      end else if (accept) begin
         cfg_ready <= 1'b0;
         stg_ch    <= cfg_ch;
         stg_num   <= cfg_num;
         stg_den   <= cfg_den;
      end else if (apply) begin
         cfg_ready <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Per-channel phase accumulators
   // ------------------------------------------------------------------
   logic [ACC_W-1:0]   num_q   [CHANNELS];
   logic [ACC_W-1:0]   den_q   [CHANNELS];
   logic [ACC_W-1:0]   acc_q   [CHANNELS];
   logic [ACC_W-1:0]   inc     [CHANNELS];
   logic [ACC_W:0]     sum     [CHANNELS];
   logic [ACC_W-1:0]   acc_nxt [CHANNELS];
   logic [CHANNELS-1:0] fire;
   logic [CHANNELS-1:0] hit;

   // NOTE: every variable gets its default at the top of the block, so no path can infer a latch.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         inc[i]     = (num_q[i] < den_q[i]) ? num_q[i] : den_q[i];
         sum[i]     = {1'b0, acc_q[i]} + {1'b0, inc[i]};
         acc_nxt[i] = sum[i][ACC_W-1:0];
         fire[i]    = 1'b0;
         hit[i]     = apply_valid && (int'(stg_ch) == i);
         if (den_q[i] == '0) begin
            acc_nxt[i] = '0;
         end else if (sum[i] >= {1'b0, den_q[i]}) begin
            acc_nxt[i] = ACC_W'(sum[i] - {1'b0, den_q[i]});
            fire[i]    = 1'b1;
         end
      end
   end

   // NOTE: the channel register arrays take the async reset too; a disabled channel (den=0) must come up silent.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            num_q[i] <= '0;
            den_q[i] <= '0;
            acc_q[i] <= '0;
         end
         outce <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
               num_q[i] <= stg_num;
               den_q[i] <= stg_den;
               acc_q[i] <= '0;
               outce[i] <= 1'b0;
            end
`ifdef CLKEN_GEN_SYNC_EN
            else if (apply_valid) begin
               acc_q[i] <= '0;
               outce[i] <= 1'b0;
            end
`endif
            else begin
               acc_q[i] <= acc_nxt[i];
               outce[i] <= fire[i];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Lock tracking: restart settling on any rate change
   // ------------------------------------------------------------------
   lock_state_t      state_q;
   lock_state_t      state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SETTLING;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (apply_valid) begin
         state_d = ST_SETTLING;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_SETTLING: begin
               if (cnt_q == CNT_LAST) state_d = ST_LOCKED;
               else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_LOCKED: state_d = ST_LOCKED;
            default:   state_d = ST_SETTLING;
         endcase
      end
   end

   assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: rate table vectors plus hand sequences for reset,
// handshake, lock timing and phase alignment; expectations flow through a scoreboard queue.
module tb_clken_gen;

   localparam int CHANNELS    = 3;
   localparam int ACC_W       = 24;
   localparam int LOCK_CYCLES = 16;

   logic                refclk = 1'b0;
   logic                rst_n;
   logic                cfg_we;
   logic [1:0]          cfg_ch;
   logic [ACC_W-1:0]    cfg_num;
   logic [ACC_W-1:0]    cfg_den;
   logic                cfg_ready;
   logic [CHANNELS-1:0] outce;
   logic                locked;

   clken_gen #(
      .CHANNELS   (CHANNELS),
      .ACC_W      (ACC_W),
      .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_num  (cfg_num),
      .cfg_den  (cfg_den),
      .cfg_ready(cfg_ready),
      .outce    (outce),
      .locked   (locked)
   );

   always #5 refclk = ~refclk;

   int edge_cnt = 0;
   always @(posedge refclk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;

   typedef struct {
      int             ch;
      logic [ACC_W-1:0] num;
      logic [ACC_W-1:0] den;
      logic [15:0]    pat;   // bit k-1 = expected outce[ch] k edges after APPLY
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[7];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ref0  = 0;   // APPLY edge that set the current ch0 phase
   int   ref2  = 0;   // APPLY edge that set the current ch2 phase

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic sb_push(input string nm, input logic [31:0] e);
      sb_t item;
      item.name = nm;
      item.exp  = e;
      sb_q.push_back(item);
   endtask

   task automatic check(input logic [31:0] act);
      sb_t item;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: actual=%0h required=a queued expectation", act);
      end else begin
         item = sb_q.pop_front();
         if (act !== item.exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", item.name, act, item.exp);
         end
      end
   endtask

   // Pulse expected at edge at_e for a channel running 1/div since APPLY edge ref_e.
   function automatic logic [31:0] exp_div(input int ref_e, input int div, input int at_e);
      int k;
      k = at_e - ref_e;
      return 32'((k > 0) && (k % div == 0));
   endfunction

   task automatic note_apply(input int ch);
      if (ch < CHANNELS) begin
`ifdef CLKEN_GEN_SYNC_EN
         ref0 = edge_cnt;
         ref2 = edge_cnt;
`else
         if (ch == 0) ref0 = edge_cnt;
         if (ch == 2) ref2 = edge_cnt;
`endif
      end
   endtask

   task automatic do_write(input int ch, input logic [ACC_W-1:0] num, input logic [ACC_W-1:0] den);
      cfg_we  = 1'b1;
      cfg_ch  = 2'(ch);
      cfg_num = num;
      cfg_den = den;
      sb_push($sformatf("wr ch%0d accept cfg_ready", ch), 32'd0);
      step();
      check(32'(cfg_ready));
      cfg_we = 1'b0;
      sb_push($sformatf("wr ch%0d apply cfg_ready", ch), 32'd1);
      step();
      check(32'(cfg_ready));
      note_apply(ch);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      vecs[0] = '{0, 24'd1, 24'd4, 16'h8888};   // 1/4: every 4th edge
      vecs[1] = '{1, 24'd3, 24'd8, 16'hA4A4};   // 3/8: positions 3,6,8 of each 8
      vecs[2] = '{2, 24'd5, 24'd5, 16'hFFFF};   // num=den: continuous
      vecs[3] = '{2, 24'd7, 24'd5, 16'hFFFF};   // num>den: continuous
      vecs[4] = '{0, 24'd0, 24'd5, 16'h0000};   // num=0: never
      vecs[5] = '{1, 24'd3, 24'd0, 16'h0000};   // den=0: disabled
      vecs[6] = '{2, 24'd2, 24'd3, 16'h6DB6};   // 2/3: positions 2,3 of each 3

      rst_n   = 1'b0;
      cfg_we  = 1'b0;
      cfg_ch  = '0;
      cfg_num = '0;
      cfg_den = '0;

      // Reset state and lock timing after release
      #12;
      sb_push("rst outce", 32'd0);      check(32'(outce));
      sb_push("rst locked", 32'd0);     check(32'(locked));
      sb_push("rst cfg_ready", 32'd1);  check(32'(cfg_ready));
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= LOCK_CYCLES; e++) begin
         sb_push($sformatf("relock edge%0d", e), 32'(e == LOCK_CYCLES));
         step();
         check(32'(locked));
      end

      // Rate table
      for (int i = 0; i < 7; i++) begin
         do_write(vecs[i].ch, vecs[i].num, vecs[i].den);
         for (int k = 1; k <= 16; k++) begin
            sb_push($sformatf("vec%0d k%0d outce", i, k), 32'(vecs[i].pat[k-1]));
            step();
            check(32'(outce[vecs[i].ch]));
         end
      end

      // Back-to-back writes: the second (5/5) must be ignored, ch0 runs 1/4
      cfg_we  = 1'b1;
      cfg_ch  = 2'd0;
      cfg_num = 24'd1;
      cfg_den = 24'd4;
      sb_push("hs accept cfg_ready", 32'd0);
      step();
      check(32'(cfg_ready));
      cfg_num = 24'd5;
      cfg_den = 24'd5;
      sb_push("hs apply cfg_ready", 32'd1);
      step();
      check(32'(cfg_ready));
      note_apply(0);
      cfg_we = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         sb_push($sformatf("hs k%0d cfg_ready", k), 32'd1);
         sb_push($sformatf("hs k%0d ch0", k), exp_div(ref0, 4, edge_cnt + 1));
         step();
         check(32'(cfg_ready));
         check(32'(outce[0]));
      end
      for (int k = 5; k <= 16; k++) begin
         sb_push($sformatf("hs k%0d locked", k), 32'(k == LOCK_CYCLES));
         sb_push($sformatf("hs k%0d ch0", k), exp_div(ref0, 4, edge_cnt + 1));
         step();
         check(32'(locked));
         check(32'(outce[0]));
      end

      // Write while LOCKED, then a second write 5 cycles after the first APPLY
      cfg_we  = 1'b1;
      cfg_ch  = 2'd2;
      cfg_num = 24'd1;
      cfg_den = 24'd2;
      sb_push("lk accept locked", 32'd1);
      step();
      check(32'(locked));
      cfg_we = 1'b0;
      sb_push("lk apply locked", 32'd0);
      step();
      check(32'(locked));
      note_apply(2);
      for (int k = 1; k <= 3; k++) begin
         sb_push($sformatf("lk hold k%0d locked", k), 32'd0);
         step();
         check(32'(locked));
      end
      do_write(2, 24'd1, 24'd2);
      for (int k = 1; k <= 16; k++) begin
         sb_push($sformatf("lk2 k%0d locked", k), 32'(k == LOCK_CYCLES));
         sb_push($sformatf("lk2 k%0d ch2", k), exp_div(ref2, 2, edge_cnt + 1));
         sb_push($sformatf("lk2 k%0d ch0", k), exp_div(ref0, 4, edge_cnt + 1));
         step();
         check(32'(locked));
         check(32'(outce[2]));
         check(32'(outce[0]));
      end

      // Out-of-range channel: handshake completes, nothing else moves
      do_write(3, 24'd1, 24'd1);
      sb_push("inv apply locked", 32'd1);
      check(32'(locked));
      for (int k = 1; k <= 4; k++) begin
         sb_push($sformatf("inv k%0d locked", k), 32'd1);
         sb_push($sformatf("inv k%0d ch0", k), exp_div(ref0, 4, edge_cnt + 1));
         sb_push($sformatf("inv k%0d ch2", k), exp_div(ref2, 2, edge_cnt + 1));
         step();
         check(32'(locked));
         check(32'(outce[0]));
         check(32'(outce[2]));
      end

      // Write ch1 mid-phase of ch0: phase kept by default, realigned with the sync build
      for (int n = 0; n < 4 && ((edge_cnt - ref0) % 4) != 1; n++) step();
      do_write(1, 24'd5, 24'd5);
      for (int k = 1; k <= 16; k++) begin
         sb_push($sformatf("ph k%0d ch0", k), exp_div(ref0, 4, edge_cnt + 1));
         sb_push($sformatf("ph k%0d ch1", k), 32'd1);
         sb_push($sformatf("ph k%0d locked", k), 32'(k == LOCK_CYCLES));
         step();
         check(32'(outce[0]));
         check(32'(outce[1]));
         check(32'(locked));
      end

      // Asynchronous reset mid-run with a write in flight
      cfg_we = 1'b1;
      cfg_ch = 2'd3;
      sb_push("pre-rst cfg_ready", 32'd0);
      sb_push("pre-rst locked", 32'd1);
      sb_push("pre-rst ch1", 32'd1);
      step();
      check(32'(cfg_ready));
      check(32'(locked));
      check(32'(outce[1]));
      cfg_we = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      sb_push("mid-rst outce", 32'd0);     check(32'(outce));
      sb_push("mid-rst locked", 32'd0);    check(32'(locked));
      sb_push("mid-rst cfg_ready", 32'd1); check(32'(cfg_ready));
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= LOCK_CYCLES; e++) begin
         sb_push($sformatf("mid relock edge%0d", e), 32'(e == LOCK_CYCLES));
         step();
         check(32'(locked));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clken_gen.md
# clken_gen

Parametrised multi-channel fractional clock-enable generator. It sits beside the system PLL wrapper and derives N independent, runtime-reprogrammable clock-enable strobes from one PLL output. Each strobe has an exact average rate of num/den of `refclk`. A PLL-style `locked` flag reports when the rates have been stable for a programmable settling time. Cores use it to produce CPU, video and audio enables without regenerating the PLL.

## Interface
- `CHANNELS`, 3, number of independent enable outputs (1–16).
- `ACC_W`, 24, width of the num/den/accumulator registers.
- `LOCK_CYCLES`, 16, stable cycles required before `locked` asserts (≥1).
- `CH_W`, derived as max(1, clog2(CHANNELS)); not overridable.

Ports:
- `refclk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: configuration write strobe; accepted only when `cfg_ready`=1.
- `cfg_ch` in CH_W: target channel index.
- `cfg_num` in ACC_W: numerator (increment).
- `cfg_den` in ACC_W: denominator (modulus).
- `cfg_ready` out 1: write port idle; 0 for exactly one cycle after an accepted write.
- `outce` out CHANNELS: registered one-cycle enable pulses, one bit per channel.
- `locked` out 1: all channels stable for `LOCK_CYCLES` consecutive cycles.

## Operation
- Per channel, registered state: `num`, `den`, `acc` (all ACC_W bits).
- Effective increment `inc` = min(num, den).
- Each cycle, compute `sum` = acc + inc in ACC_W+1 bits.
  - If den≠0 and sum ≥ den: acc ← sum − den, outce[ch] ← 1.
  - Otherwise: acc ← sum[ACC_W-1:0], outce[ch] ← 0.
- den=0 disables the channel: outce=0 and acc held at 0.
- num=0 means the channel never fires.
- num ≥ den means the channel fires every cycle.
- Write pipeline, in two stages:
  - ACCEPT: on `cfg_we`=1 and `cfg_ready`=1, capture ch/num/den into staging registers; `cfg_ready` ← 0.
  - APPLY (next edge): load num/den into the target channel, clear its acc, `cfg_ready` ← 1.
- `cfg_we` while `cfg_ready`=0 is ignored; no queueing.
- If `cfg_ch` ≥ CHANNELS, the handshake completes normally but no channel changes and `locked` is unaffected.
- Lock FSM, two states:
  - SETTLING: counter counts up each cycle; at count = LOCK_CYCLES−1, go to LOCKED (`locked` ← 1).
  - LOCKED: holds.
  - Any APPLY to a valid channel forces SETTLING with counter=0 and `locked` ← 0, from either state, including an APPLY during SETTLING.

## Timing
- Reset values (asynchronous on `rst_n`=0, outputs change without a clock edge):
  - `outce`=0, `locked`=0, `cfg_ready`=1.
  - All num/den/acc = 0; FSM = SETTLING with counter=0.
- After reset release, `locked` rises on the LOCK_CYCLES-th edge.
- Write at edge N:
  - `cfg_ready`=0 after N; channel updated at N+1; `cfg_ready`=1 after N+1.
  - Earliest new-rate `outce` pulse: registered at edge N+2.
  - `locked`=0 after N+1; `locked` rises after edge N+1+LOCK_CYCLES if no further writes occur.
- While a channel is being written, the other channels keep running uninterrupted (without the macro).
- `outce` is a pulse of exactly one cycle, or continuous high when inc=den.

## Configuration
- `CLKEN_GEN_SYNC_EN` defined: APPLY clears acc of all channels in the same cycle. Every phase realigns, so all channels restart their sequences together.
- `CLKEN_GEN_SYNC_EN` undefined: only the written channel's acc clears; other phases are untouched.

## Test plan
- Reset: hold `rst_n`=0 mid-run → `outce`=0, `locked`=0 and `cfg_ready`=1 immediately. Release → `locked`=1 after exactly 16 edges.
- Write ch0 num=1 den=4 → ch0 pulses on the 4th, 8th, 12th… cycles after APPLY. Write ch1 num=3 den=8 → pulses at positions 3, 6, 8 of each 8-cycle period (3 per 8).
- Boundary rates:
  - num=den=5 → `outce` continuously high.
  - num=7 den=5 → continuously high.
  - num=0 den=5 → never fires.
  - den=0 → never fires, acc stays 0.
- Handshake: `cfg_we` on two consecutive cycles → second write ignored, `cfg_ready` low for one cycle only. A write with `cfg_ch`=3 (CHANNELS=3) → no channel change and `locked` stays 1.
- Lock: write during LOCKED → `locked` falls the next cycle. A second write 5 cycles later → `locked` rises 16 cycles after the second APPLY.
- Macro: ch0=1/4 running, write ch1 at arbitrary phase → ch0 phase resets with `CLKEN_GEN_SYNC_EN` defined and is unchanged with it undefined.
